fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, byte address of the first fetched instruction.
REQ-002 Parameter IMEM_AW, 12, instruction-memory word-address width.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 pcsrc_EX  input  2  control-unit PC select: 0 = sequential, 1 = jal, 2 = jalr, 3 = reserved.
REQ-006 stall_FETCH  input  1  control-unit redirect request for the instruction in EX.
REQ-007 jal_target_EX  input  32  jal target byte address, computed in EX.
REQ-008 jalr_target_EX  input  32  jalr target byte address (rs1+imm), computed in EX.
REQ-009 imem_req  output  1  request strobe; one request accepted per cycle it is high.
REQ-010 imem_addr  output  IMEM_AW  word address (request byte address [IMEM_AW+1:2]).
REQ-011 imem_rvalid  input  1  response valid; at least 1 cycle after its request, in request order.
REQ-012 imem_rdata  input  32  instruction word, valid with imem_rvalid.
REQ-013 instruction_EX  output  32  instruction presented to decode/EX.
REQ-014 pc_EX  output  32  byte address of instruction_EX.
REQ-015 stall_EX  output  1  1 = instruction_EX is a bubble; the control unit suppresses writeback.
REQ-016 misalign_fault  output  1  sticky misaligned-redirect flag.

Function
REQ-017 The FSM SHALL have states START, WAIT (one request outstanding), DROP (outstanding response to be discarded) and HALT.
REQ-018 redirect SHALL equal !stall_EX && stall_FETCH && (pcsrc_EX==1 || pcsrc_EX==2); pcsrc_EX==3 and any pcsrc while stall_EX=1 SHALL be ignored.
REQ-019 target SHALL be jal_target_EX for pcsrc 1 and {jalr_target_EX[31:1],1'b0} for pcsrc 2.
REQ-020 Register fetch_pc holds the next address to request; req_addr SHALL be target when redirect, else fetch_pc.
REQ-021 imem_req SHALL be high in START, and in WAIT or DROP in a cycle with imem_rvalid=1; low otherwise (at most one outstanding request).
REQ-022 On each issued request: inflight_pc <= req_addr, fetch_pc <= req_addr+4 (32-bit wrap), state <= WAIT.
REQ-023 WAIT with imem_rvalid=1 and no redirect SHALL load instruction_EX <= imem_rdata, pc_EX <= inflight_pc, stall_EX <= 0.
REQ-024 In every other cycle stall_EX SHALL become 1, instruction_EX SHALL become 32'h0000_0013 (NOP), and pc_EX SHALL hold.
REQ-025 redirect in WAIT with imem_rvalid=1: response discarded, request to target issued in the same cycle.
REQ-026 redirect in WAIT with imem_rvalid=0: state <= DROP, fetch_pc <= target, imem_req low.
REQ-027 redirect in DROP without rvalid: fetch_pc <= newest target; DROP with rvalid: discard response, issue request to req_addr.
REQ-028 redirect in START: first request goes to target instead of RESET_PC.
REQ-029 With 1-cycle memory: throughput 1 instruction/cycle; first valid instruction_EX 2 cycles after reset release; jal/jalr penalty exactly 1 bubble.
REQ-030 HALT SHALL keep imem_req=0, stall_EX=1 and ignore all responses until reset.

Reset
REQ-031 Asserting rst_n=0 at any time, including with a request outstanding, SHALL immediately force: state START, fetch_pc=RESET_PC, inflight_pc=RESET_PC, pc_EX=RESET_PC, instruction_EX=32'h0000_0013, stall_EX=1, misalign_fault=0.
REQ-032 Responses to requests issued before reset are the memory's responsibility to cancel; the unit does not track them.

Configuration
REQ-033 FETCH_MISALIGN_EN defined: a redirect with target[1]=1 SHALL set misalign_fault=1, enter HALT, and issue no request that cycle.
REQ-034 FETCH_MISALIGN_EN undefined: target[1:0] SHALL be forced to 2'b00 and misalign_fault SHALL be tied 0.

Verification
REQ-035 Reset release, 1-cycle memory returning addi words -> imem_addr 0,1,2,... on consecutive cycles; pc_EX 0,4,8 with stall_EX=0 from cycle 2.
REQ-036 jal at pc 0x8, target 0x40 -> response for 0xC discarded, one NOP bubble, then pc_EX=0x40, stall_EX=0.
REQ-037 3-cycle memory latency, redirect to 0x100 during WAIT -> DROP, stale response discarded, next request imem_addr=0x40, no stale instruction reaches EX.
REQ-038 pcsrc_EX=1, stall_FETCH=1 with stall_EX=1 -> no redirect, sequential fetch continues.
REQ-039 jalr target 0x102 -> with FETCH_MISALIGN_EN misalign_fault=1 and imem_req stays 0; without it next request to byte 0x100.
REQ-040 rst_n dropped mid-WAIT -> outputs at reset values immediately; after release fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction-memory request/response bus between fetch_unit and imem
interface fetch_unit_if #(
    parameter int IMEM_AW = 12
) ();
    logic               imem_req;
    logic [IMEM_AW-1:0] imem_addr;
    logic               imem_rvalid;
    logic [31:0]        imem_rdata;

    // Fetch side issues requests and consumes responses
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    // Memory side accepts requests and returns responses in order
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-outstanding instruction fetch with jal/jalr redirect (optional FETCH_MISALIGN_EN)
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        pcsrc_EX,
    input  logic              stall_FETCH,
    input  logic [31:0]       jal_target_EX,
    input  logic [31:0]       jalr_target_EX,
    fetch_unit_if.master      imem,
    output logic [31:0]       instruction_EX,
    output logic [31:0]       pc_EX,
    output logic              stall_EX,
    output logic              misalign_fault
);

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DROP  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] inflight_pc_q, inflight_pc_d;
    logic [31:0] pc_ex_q, pc_ex_d;
    logic [31:0] instr_ex_q, instr_ex_d;
    logic        stall_ex_q, stall_ex_d;
    logic        fault_q, fault_d;

    logic        redirect;
    logic        misalign;
    logic        req_slot;
    logic        issue;
    logic [31:0] target_raw;
    logic [31:0] target;
    logic [31:0] req_addr;

    // Redirect decode, target selection and request issue decision
    always_comb begin
        // A bubble in EX carries no valid jump, so its pcsrc is ignored
        redirect   = !stall_ex_q && stall_FETCH && (pcsrc_EX == 2'd1 || pcsrc_EX == 2'd2);
        target_raw = (pcsrc_EX == 2'd2) ? (jalr_target_EX & 32'hFFFF_FFFE) : jal_target_EX;
`ifdef FETCH_MISALIGN_EN
        target     = target_raw;
        misalign   = redirect && target_raw[1];
`else
        target     = target_raw & 32'hFFFF_FFFC;
        misalign   = 1'b0;
`endif
        req_addr   = redirect ? target : fetch_pc_q;

        // A new request may go out only when no response is still owed
        case (state_q)
            ST_START: req_slot = 1'b1;
            ST_WAIT:  req_slot = imem.imem_rvalid;
            ST_DROP:  req_slot = imem.imem_rvalid;
            default:  req_slot = 1'b0;
        endcase
        issue = req_slot && !misalign;
    end

    assign imem.imem_req  = issue;
    assign imem.imem_addr = req_addr[IMEM_AW+1:2];

    // Next-state and next-output computation for the fetch FSM
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        pc_ex_d       = pc_ex_q;
        instr_ex_d    = NOP_INSTR;
        stall_ex_d    = 1'b1;
        fault_d       = fault_q;

        if (state_q != ST_HALT) begin
            if (misalign) begin
                fault_d = 1'b1;
                state_d = ST_HALT;
            end else if (issue) begin
                inflight_pc_d = req_addr;
                fetch_pc_d    = req_addr + 32'd4;
                state_d       = ST_WAIT;
            end else if (redirect) begin
                // Response still owed: park the new target and discard what comes back
                fetch_pc_d = target;
                state_d    = ST_DROP;
            end

            if (state_q == ST_WAIT && imem.imem_rvalid && !redirect) begin
                instr_ex_d = imem.imem_rdata;
                pc_ex_d    = inflight_pc_q;
                stall_ex_d = 1'b0;
            end
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_START;
            fetch_pc_q    <= RESET_PC;
            inflight_pc_q <= RESET_PC;
            pc_ex_q       <= RESET_PC;
            instr_ex_q    <= NOP_INSTR;
            stall_ex_q    <= 1'b1;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            inflight_pc_q <= inflight_pc_d;
            pc_ex_q       <= pc_ex_d;
            instr_ex_q    <= instr_ex_d;
            stall_ex_q    <= stall_ex_d;
            fault_q       <= fault_d;
        end
    end

    assign instruction_EX = instr_ex_q;
    assign pc_EX          = pc_ex_q;
    assign stall_EX       = stall_ex_q;
    assign misalign_fault = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized and directed self-checking bench for fetch_unit
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  pcsrc_EX;
    logic        stall_FETCH;
    logic [31:0] jal_target_EX;
    logic [31:0] jalr_target_EX;
    logic [31:0] instruction_EX;
    logic [31:0] pc_EX;
    logic        stall_EX;
    logic        misalign_fault;

    always #5 clk = ~clk;

    fetch_unit_if #(.IMEM_AW(12)) imem ();

    fetch_unit #(.RESET_PC(32'h0000_0000), .IMEM_AW(12)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pcsrc_EX       (pcsrc_EX),
        .stall_FETCH    (stall_FETCH),
        .jal_target_EX  (jal_target_EX),
        .jalr_target_EX (jalr_target_EX),
        .imem           (imem),
        .instruction_EX (instruction_EX),
        .pc_EX          (pc_EX),
        .stall_EX       (stall_EX),
        .misalign_fault (misalign_fault)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_pc, last_pc;
    bit          pend;
    int          pend_cnt;
    logic [11:0] pend_addr;
    int          lat_min = 1, lat_max = 1;
    int          mode = 0;
    bit          dir_armed;
    logic [31:0] dir_pc, dir_tgt;
    logic [1:0]  dir_src;
    bit          redir_drv;
    bit          watch = 1'b1;
    int          bubble_run;
    int          commits;
    logic        obs_stall, obs_req, obs_rvalid;
    logic [31:0] obs_pc;
    logic [11:0] obs_addr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Memory image: word at word-address a is "addi x0, x0, a"
    function automatic logic [31:0] mem_word(input logic [11:0] wa);
        return {wa, 20'h00013};
    endfunction

    function automatic logic [31:0] exp_target(input logic [1:0] src, input logic [31:0] j,
                                               input logic [31:0] jr);
        logic [31:0] t;
        t = (src == 2'd2) ? (jr & 32'hFFFF_FFFE) : j;
`ifndef FETCH_MISALIGN_EN
        t = t & 32'hFFFF_FFFC;
`endif
        return t;
    endfunction

    // One cycle of work, called at posedge+1: check EX, drive memory and control, sample request
    task automatic step_body();
        int r;
        obs_stall = stall_EX;
        obs_pc    = pc_EX;
        if (!stall_EX) begin
            check("ex_pc", pc_EX, exp_pc);
            check("ex_instr", instruction_EX, mem_word(exp_pc[13:2]));
            last_pc    = pc_EX;
            commits++;
            bubble_run = 0;
        end else begin
            check("bubble_nop", instruction_EX, NOP);
            check("bubble_pc_hold", pc_EX, last_pc);
            bubble_run++;
            if (watch && bubble_run > 15) begin
                check("progress_bubbles", bubble_run, 0);
                bubble_run = 0;
            end
        end

        imem.imem_rvalid = 1'b0;
        imem.imem_rdata  = $urandom;
        if (pend) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                imem.imem_rvalid = 1'b1;
                imem.imem_rdata  = mem_word(pend_addr);
                pend             = 1'b0;
            end
        end

        stall_FETCH    = 1'b0;
        pcsrc_EX       = 2'd0;
        jal_target_EX  = $urandom;
        jalr_target_EX = $urandom;
        redir_drv      = 1'b0;
        r = $urandom_range(0, 99);
        if (mode == 1) begin
            if (!stall_EX && r < 25) begin
                stall_FETCH = 1'b1;
                pcsrc_EX    = 2'($urandom_range(1, 2));
`ifdef FETCH_MISALIGN_EN
                jal_target_EX  = jal_target_EX & 32'hFFFF_FFFC;
                jalr_target_EX = jalr_target_EX & 32'hFFFF_FFFC;
`endif
                redir_drv = 1'b1;
            end else if (r < 50) begin
                stall_FETCH = 1'b1;
                pcsrc_EX    = stall_EX ? 2'($urandom_range(1, 2)) : 2'd3;
            end else begin
                pcsrc_EX = 2'($urandom_range(0, 3));
            end
        end else if (mode == 2) begin
            if (dir_armed && !stall_EX && pc_EX == dir_pc) begin
                stall_FETCH    = 1'b1;
                pcsrc_EX       = dir_src;
                jal_target_EX  = dir_tgt;
                jalr_target_EX = dir_tgt;
                redir_drv      = 1'b1;
                dir_armed      = 1'b0;
            end
        end else if (mode == 3) begin
            stall_FETCH    = 1'b1;
            jal_target_EX  = 32'h0000_0200;
            jalr_target_EX = 32'h0000_0200;
            pcsrc_EX       = stall_EX ? 2'($urandom_range(1, 2)) : 2'd3;
        end
        if (!stall_EX)
            exp_pc = redir_drv ? exp_target(pcsrc_EX, jal_target_EX, jalr_target_EX) : pc_EX + 32'd4;

        #1;
        obs_req    = imem.imem_req;
        obs_addr   = imem.imem_addr;
        obs_rvalid = imem.imem_rvalid;
        if (obs_req) begin
            check("one_outstanding", 32'(pend), 0);
            pend      = 1'b1;
            pend_cnt  = $urandom_range(lat_min, lat_max);
            pend_addr = obs_addr;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        step_body();
    endtask

    // Hold reset, check reset outputs, release; the release cycle is cycle 0
    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst_n            = 1'b0;
        pend             = 1'b0;
        imem.imem_rvalid = 1'b0;
        stall_FETCH      = 1'b0;
        pcsrc_EX         = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall", 32'(stall_EX), 1);
        check("rst_instr", instruction_EX, NOP);
        check("rst_pc", pc_EX, 32'h0);
        check("rst_fault", 32'(misalign_fault), 0);
        rst_n      = 1'b1;
        exp_pc     = 32'h0;
        last_pc    = 32'h0;
        bubble_run = 0;
        commits    = 0;
        step_body();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n            = 1'b0;
        stall_FETCH      = 1'b0;
        pcsrc_EX         = 2'd0;
        jal_target_EX    = '0;
        jalr_target_EX   = '0;
        imem.imem_rvalid = 1'b0;
        imem.imem_rdata  = '0;

        // Straight-line fetch with 1-cycle memory
        mode = 0; lat_min = 1; lat_max = 1;
        apply_reset();
        check("c0_req", 32'(obs_req), 1);
        check("c0_addr", 32'(obs_addr), 0);
        step();
        check("c1_addr", 32'(obs_addr), 1);
        check("c1_stall", 32'(obs_stall), 1);
        step();
        check("c2_addr", 32'(obs_addr), 2);
        check("c2_stall", 32'(obs_stall), 0);
        check("c2_pc", obs_pc, 32'h0);
        step();
        check("c3_pc", obs_pc, 32'h4);
        step();
        check("c4_pc", obs_pc, 32'h8);
        for (int i = 0; i < 8; i++) begin
            step();
            check("throughput", 32'(obs_stall), 0);
        end

        // jal at 0x8 to 0x40: exactly one bubble
        mode = 2; dir_armed = 1'b1; dir_pc = 32'h8; dir_src = 2'd1; dir_tgt = 32'h40;
        apply_reset();
        for (int i = 0; i < 20 && !redir_drv; i++) step();
        check("jal_seen", 32'(redir_drv), 1);
        check("jal_req_addr", 32'(obs_addr), 32'h10);
        step();
        check("jal_bubble", 32'(obs_stall), 1);
        step();
        check("jal_land_stall", 32'(obs_stall), 0);
        check("jal_land_pc", obs_pc, 32'h40);

        // 3-cycle memory, redirect to 0x100 while a response is owed
        mode = 2; dir_armed = 1'b1; dir_pc = 32'h4; dir_src = 2'd1; dir_tgt = 32'h100;
        lat_min = 3; lat_max = 3;
        apply_reset();
        for (int i = 0; i < 40 && !redir_drv; i++) step();
        check("drop_seen", 32'(redir_drv), 1);
        check("drop_no_req", 32'(obs_req), 0);
        step();
        for (int i = 0; i < 10 && !obs_req; i++) step();
        check("drop_next_addr", 32'(obs_addr), 32'h40);
        check("drop_stale_rvalid", 32'(obs_rvalid), 1);
        step();
        for (int i = 0; i < 10 && obs_stall; i++) step();
        check("drop_land_pc", obs_pc, 32'h100);

        // pcsrc while EX holds a bubble (and pcsrc 3) must be ignored
        mode = 3; lat_min = 2; lat_max = 2;
        apply_reset();
        repeat (30) step();
        check("noise_progress", 32'(commits > 8), 1);

        // jalr to 0x102
        mode = 2; dir_armed = 1'b1; dir_pc = 32'h8; dir_src = 2'd2; dir_tgt = 32'h102;
        lat_min = 1; lat_max = 1;
        apply_reset();
        for (int i = 0; i < 20 && !redir_drv; i++) step();
        check("jalr_seen", 32'(redir_drv), 1);
`ifdef FETCH_MISALIGN_EN
        watch = 1'b0;
        check("mis_no_req", 32'(obs_req), 0);
        step();
        check("mis_fault", 32'(misalign_fault), 1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("halt_no_req", 32'(obs_req), 0);
            check("halt_stall", 32'(obs_stall), 1);
        end
        watch = 1'b1;
`else
        check("jalr_req", 32'(obs_req), 1);
        check("jalr_addr", 32'(obs_addr), 32'h40);
        step();
        step();
        check("jalr_land_pc", obs_pc, 32'h100);
        check("jalr_no_fault", 32'(misalign_fault), 0);
`endif

        // Asynchronous reset with a request outstanding
        mode = 0; lat_min = 1; lat_max = 1;
        apply_reset();
        repeat (6) step();
        check("pre_rst_pc", obs_pc, 32'h10);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_stall", 32'(stall_EX), 1);
        check("arst_instr", instruction_EX, NOP);
        check("arst_pc", pc_EX, 32'h0);
        check("arst_fault", 32'(misalign_fault), 0);
        apply_reset();
        check("rerun_addr0", 32'(obs_addr), 0);
        step();
        step();
        check("rerun_pc0", obs_pc, 32'h0);
        check("rerun_stall", 32'(obs_stall), 0);

        // Randomized traffic: variable latency, random jal/jalr and ignored noise
        mode = 1; lat_min = 1; lat_max = 3;
        apply_reset();
        repeat (3000) step();
        check("rand_progress", 32'(commits > 300), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
